// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit with valid/ready request handshake.
// Define FAST_MUL_EN for a single-cycle array multiply on MUL/MULH/MULHSU/MULHU.
module muldiv_unit #(
  parameter  int DWIDTH = 32,
  localparam int CWIDTH = $clog2(DWIDTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        funct3_i,
  input  logic [DWIDTH-1:0] rs1_i,
  input  logic [DWIDTH-1:0] rs2_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              valid_o,
  output logic [DWIDTH-1:0] res_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [DWIDTH-1:0] MIN_INT = {1'b1, {(DWIDTH-1){1'b0}}};

  state_t              state, state_n;
  logic [CWIDTH-1:0]   cnt;
  logic [2*DWIDTH-1:0] acc;
  logic [DWIDTH-1:0]   opnd;
  logic [DWIDTH-1:0]   out_q;
  logic [2:0]          op_q;
  logic                neg_q;
  logic                spec_q;
  logic                valid_q;

  logic                accept;
  logic                signed_a, signed_b;
  logic                sa, sb;
  logic [DWIDTH-1:0]   mag_a, mag_b;
  logic                div_zero, ovf, special;
  logic [DWIDTH-1:0]   spec_res;
  logic                neg_n;

  assign ready_o = (state == IDLE);
  assign busy_o  = (state != IDLE);
  assign valid_o = valid_q & ~flush_i;
  assign accept  = valid_i & ready_o & ~flush_i;

  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (funct3_i)
      3'd0, 3'd1, 3'd4, 3'd6: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
      end
      3'd2:    signed_a = 1'b1;
      default: ;
    endcase
  end

  assign sa    = signed_a & rs1_i[DWIDTH-1];
  assign sb    = signed_b & rs2_i[DWIDTH-1];
  assign mag_a = sa ? (~rs1_i + 1'b1) : rs1_i;
  assign mag_b = sb ? (~rs2_i + 1'b1) : rs2_i;
  // remainder follows the dividend sign, everything else the product sign
  assign neg_n = (funct3_i[2] & funct3_i[1]) ? sa : (sa ^ sb);

  assign div_zero = funct3_i[2] && (rs2_i == '0);
  assign ovf      = (funct3_i == 3'd4 || funct3_i == 3'd6) &&
                    (rs1_i == MIN_INT) && (rs2_i == '1);
  assign special  = div_zero | ovf;

  always_comb begin
    spec_res = '0;
    if (div_zero)
      spec_res = funct3_i[1] ? rs1_i : '1;
    else if (ovf)
      spec_res = funct3_i[1] ? '0 : MIN_INT;
  end

  // one radix-2 step: shift-add for mul, restoring shift-subtract for div
  logic [DWIDTH:0]     sum;
  logic [DWIDTH:0]     r;
  logic [DWIDTH:0]     diff;
  logic [DWIDTH-1:0]   hi_n;
  logic [2*DWIDTH-1:0] step_mul, step_div;

  always_comb begin
    sum      = {1'b0, acc[2*DWIDTH-1:DWIDTH]} +
               (acc[0] ? {1'b0, opnd} : '0);
    step_mul = {sum, acc[DWIDTH-1:1]};
    r        = {acc[2*DWIDTH-1:DWIDTH], acc[DWIDTH-1]};
    diff     = r - {1'b0, opnd};
    hi_n     = diff[DWIDTH] ? r[DWIDTH-1:0] : diff[DWIDTH-1:0];
    step_div = {hi_n, acc[DWIDTH-2:0], ~diff[DWIDTH]};
  end

  logic [2*DWIDTH-1:0] prod;
  logic [DWIDTH-1:0]   quo, rem;
  logic [DWIDTH-1:0]   fix_res;

  always_comb begin
    prod = neg_q ? (~acc + 1'b1) : acc;
    quo  = neg_q ? (~acc[DWIDTH-1:0] + 1'b1) : acc[DWIDTH-1:0];
    rem  = neg_q ? (~acc[2*DWIDTH-1:DWIDTH] + 1'b1)
                 : acc[2*DWIDTH-1:DWIDTH];
    case (op_q)
      3'd0:             fix_res = prod[DWIDTH-1:0];
      3'd1, 3'd2, 3'd3: fix_res = prod[2*DWIDTH-1:DWIDTH];
      3'd4, 3'd5:       fix_res = quo;
      default:          fix_res = rem;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (special)
            state_n = FIX;
`ifdef FAST_MUL_EN
          else if (!funct3_i[2])
            state_n = FIX;
`endif
          else
            state_n = CALC;
        end
      end
      CALC: if (cnt == CWIDTH'(DWIDTH-1)) state_n = FIX;
      FIX:  state_n = DONE;
      DONE: state_n = IDLE;
    endcase
    if (flush_i)
      state_n = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      out_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      spec_q  <= 1'b0;
      valid_q <= 1'b0;
      res_o   <= '0;
    end else begin
      valid_q <= 1'b0;
      if (flush_i) begin
        cnt <= '0;
      end else begin
        unique case (state)
          IDLE: if (accept) begin
            op_q   <= funct3_i;
            neg_q  <= neg_n;
            spec_q <= special;
            out_q  <= spec_res;
            cnt    <= '0;
            opnd   <= funct3_i[2] ? mag_b : mag_a;
`ifdef FAST_MUL_EN
            if (funct3_i[2])
              acc <= {{DWIDTH{1'b0}}, mag_a};
            else
              acc <= {{DWIDTH{1'b0}}, mag_a} *
                     {{DWIDTH{1'b0}}, mag_b};
`else
            acc <= {{DWIDTH{1'b0}},
                    funct3_i[2] ? mag_a : mag_b};
`endif
          end
          CALC: begin
            cnt <= cnt + 1'b1;
            acc <= op_q[2] ? step_div : step_mul;
          end
          FIX: if (!spec_q) out_q <= fix_res;
          DONE: begin
            res_o   <= out_q;
            valid_q <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
